// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_t        : FSM state encoding (IDLE=00, RUN=01, PAUSE=10)
//   DEFAULT_DIGITS : default number of BCD digits in the count
//   BCD_MAX        : largest legal value of one BCD digit
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int          DEFAULT_DIGITS = 4;
  localparam logic [3:0]  BCD_MAX        = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the stopwatch count.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset, clears the digit
//   clr       : synchronous clear, overrides inc
//   inc       : increment enable (count enable for the LSD, carry for others)
//   q         : current digit value, always 0..9
//   carry_out : high when this digit rolls 9->0 on this cycle's increment
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  // Carry is combinational so a whole chain of 9s rolls over in one edge.
  assign carry_out = inc & ~clr & (r_q == BCD_MAX);
  assign q         = r_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM driving a DIGITS-wide BCD counter.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   tick       : one-cycle count enable (level; counted every RUN cycle it is high)
//   start_stop : debounced button level, each rising edge toggles run/pause
//   clear      : synchronous clear, priority over tick and press
//   count      : packed BCD count, LSD in [3:0]
//   running    : registered, high exactly while in RUN
//   overflow   : sticky wrap flag (all-9s -> all-0s), cleared by clear/reset
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_stop,
  input  logic                clear,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                overflow
);

  state_t              r_state;
  state_t              w_next;
  logic                r_ss_q;
  logic                r_armed;
  logic                r_running;
  logic                r_overflow;
  logic                w_press;
  logic                w_count_en;
  logic [DIGITS-1:0]   w_inc;
  logic [DIGITS-1:0]   w_carry;

  // r_armed stays low after reset until the button is seen released, so a
  // button already held through reset release cannot produce a press.
  assign w_press = start_stop & ~r_ss_q & r_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_count_en = 1'b0;
    if (clear) begin
      w_next = IDLE;
    end else begin
      // Tick is judged against the current state, so a press in the same
      // cycle counts the tick from RUN but not from PAUSE.
      w_count_en = (r_state == RUN) & tick;
      if (w_press) begin
        case (r_state)
          IDLE:    w_next = RUN;
          RUN:     w_next = PAUSE;
          PAUSE:   w_next = RUN;
          default: w_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ss_q     <= 1'b0;
      r_armed    <= 1'b0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ss_q <= start_stop;
      if (!start_stop) begin
        r_armed <= 1'b1;
      end
      // Decoding the next state keeps running aligned with r_state.
      r_running <= (w_next == RUN);
      if (clear) begin
        r_overflow <= 1'b0;
      end else if (w_carry[DIGITS-1]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign w_inc[g] = w_count_en;
    end else begin : g_upper
      assign w_inc[g] = w_carry[g-1];
    end

    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear),
      .inc       (w_inc[g]),
      .q         (count[4*g +: 4]),
      .carry_out (w_carry[g])
    );
  end

  assign running  = r_running;
  assign overflow = r_overflow;

endmodule
